// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with one write port and two
// registered read ports. Register 0 can optionally be hard-wired to zero,
// and a same-edge write to a register being read can optionally be
// forwarded straight to the read outputs.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    // DEPTH can equal 2**ADDR_WIDTH, so it needs one extra bit to compare
    // against a zero-extended address without truncation.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dataR1;
    logic [DATA_WIDTH-1:0] r_dataR2;

    logic                  w_writeOk;
    logic [DEPTH-1:0]      w_wrSel;
    logic                  w_rd1Valid;
    logic                  w_rd2Valid;
    logic [DATA_WIDTH-1:0] w_rd1Value;
    logic [DATA_WIDTH-1:0] w_rd2Value;

    // A write is kept only when it targets a real register that is not the hard-wired zero.
    always_comb begin
        w_writeOk = WRITE
                    && ({1'b0, ADDR_W} < LP_DEPTH)
                    && !((ZERO_REG != 0) && (ADDR_W == '0));
    end

    // One-hot load-enable decode; at most one register loads per edge.
    always_comb begin
        w_wrSel = '0;
        if (w_writeOk) begin
            w_wrSel[ADDR_W] = 1'b1;
        end
    end

    // Read addresses outside the file, or the zero register, always yield zero.
    always_comb begin
        w_rd1Valid = ({1'b0, ADDR_R1} < LP_DEPTH)
                     && !((ZERO_REG != 0) && (ADDR_R1 == '0));
        w_rd2Valid = ({1'b0, ADDR_R2} < LP_DEPTH)
                     && !((ZERO_REG != 0) && (ADDR_R2 == '0));
    end

    // Port 1 read value, forwarding the incoming write data when bypass is enabled.
    always_comb begin
        w_rd1Value = '0;
        if (w_rd1Valid) begin
            if ((BYPASS != 0) && w_writeOk && (ADDR_R1 == ADDR_W)) begin
                w_rd1Value = DATA_W;
            end else begin
                w_rd1Value = r_mem[ADDR_R1];
            end
        end
    end

    // Port 2 read value, evaluated independently of port 1.
    always_comb begin
        w_rd2Value = '0;
        if (w_rd2Valid) begin
            if ((BYPASS != 0) && w_writeOk && (ADDR_R2 == ADDR_W)) begin
                w_rd2Value = DATA_W;
            end else begin
                w_rd2Value = r_mem[ADDR_R2];
            end
        end
    end

    // Register storage: cleared by reset, otherwise only the selected entry loads.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wrSel[i]) begin
                    r_mem[i] <= DATA_W;
                end
            end
        end
    end

    // Registered read outputs, updated together only when READ is high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_dataR1 <= '0;
            r_dataR2 <= '0;
        end else if (READ) begin
            r_dataR1 <= w_rd1Value;
            r_dataR2 <= w_rd2Value;
        end
    end

    assign DATA_R1 = r_dataR1;
    assign DATA_R2 = r_dataR2;

endmodule
